// File: rtl/snn_pkg.sv
// Shared SNN constants, receive-FSM encoding and row helpers used by the
// presynaptic buffer and its row reduction stage.
package snn_pkg;

  localparam int SNN_ROWS  = 24;
  localparam int SNN_NRNS  = 18;
  localparam int TRACE_W   = 16;
  localparam int GRP_LANES = 6;
  localparam int N_GRP     = 4;
  localparam int POP_W     = 5;
  localparam int PSUM_W    = 19;
  localparam int ROWSUM_W  = 21;
  localparam int SPK_ACC_W = 10;
  localparam int LTP_ACC_W = 26;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_e;

  function automatic logic [POP_W-1:0] popcount_row(input logic [SNN_ROWS-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = {POP_W{1'b0}};
    for (int i = 0; i < SNN_ROWS; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/row_reduce.sv
// Stage 1 of the row pipeline: spike popcount and four 6-lane partial trace
// sums, captured only on accepted beats.
module row_reduce
  import snn_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_en,
  input  logic [SNN_ROWS-1:0]               i_spike_bundle,
  input  logic [SNN_ROWS*TRACE_W-1:0]       i_trace,
  output logic [POP_W-1:0]                  o_pop,
  output logic [N_GRP-1:0][PSUM_W-1:0]      o_psum
);

  logic [POP_W-1:0]             pop_d, pop_q;
  logic [N_GRP-1:0][PSUM_W-1:0] psum_d, psum_q;

  // Popcount and per-group lane adders
  always_comb begin
    pop_d = popcount_row(i_spike_bundle);
    for (int g = 0; g < N_GRP; g++) begin
      psum_d[g] = {PSUM_W{1'b0}};
      for (int j = 0; j < GRP_LANES; j++) begin
        psum_d[g] = psum_d[g]
                  + {{(PSUM_W-TRACE_W){1'b0}}, i_trace[(g*GRP_LANES+j)*TRACE_W +: TRACE_W]};
      end
    end
  end

  // Stage-1 registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_q  <= {POP_W{1'b0}};
      psum_q <= {(N_GRP*PSUM_W){1'b0}};
    end else if (i_en) begin
      pop_q  <= pop_d;
      psum_q <= psum_d;
    end
  end

  assign o_pop  = pop_q;
  assign o_psum = psum_q;

endmodule

// File: rtl/pre_bundle_rx.sv
// Presynaptic bundle receiver: accumulates 24-row passes into per-neuron spike
// counts and LTP trace sums, gated by the postsynaptic fire flag of each pass.
module pre_bundle_rx
  import snn_pkg::*;
#(
  parameter int ROWS = SNN_ROWS,
  parameter int NRNS = SNN_NRNS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SNN_ROWS-1:0]         i_spike_bundle,
  input  logic [SNN_ROWS*TRACE_W-1:0] i_trace,
  input  logic                        i_valid,
  input  logic                        i_done,
  input  logic [SNN_NRNS-1:0]         i_post_spike,
  output logic                        o_nrn_valid,
  output logic [IDX_W-1:0]            o_nrn_idx,
  output logic [SPK_ACC_W-1:0]        o_nrn_spike_cnt,
  output logic [LTP_ACC_W-1:0]        o_ltp_sum,
  output logic                        o_frame_done,
  output logic                        o_err,
  output logic                        o_busy
);

  localparam int                FRAME_BEATS = ROWS * NRNS;
  localparam int                BEAT_W      = $clog2(FRAME_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(FRAME_BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_ROW    = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]  LAST_NRN    = IDX_W'(NRNS - 1);

  rx_state_e             state_q, state_d;
  logic [IDX_W-1:0]      row_q, row_d, pass_q, pass_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  busy_q;
  logic                  accept, abort, last_row;

  logic                  p1_vld_q, p1_last_q, p1_post_q;
  logic [IDX_W-1:0]      p1_idx_q, p2_idx_q;
  logic                  p2_last_q, p2_post_q;

  logic [POP_W-1:0]             pop;
  logic [N_GRP-1:0][PSUM_W-1:0] psum;
  logic [ROWSUM_W-1:0]          row_sum;
  logic                         contrib_en, clear_acc;
  logic [SPK_ACC_W-1:0]         spk_add, spk_acc_q, spk_acc_d;
  logic [LTP_ACC_W-1:0]         ltp_add, ltp_acc_q, ltp_acc_d;

  logic                  nrn_valid_q, frame_done_q;
  logic [IDX_W-1:0]      nrn_idx_q;
  logic [SPK_ACC_W-1:0]  nrn_cnt_q;
  logic [LTP_ACC_W-1:0]  ltp_sum_q;

  row_reduce u_row_reduce (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_en           (accept),
    .i_spike_bundle (i_spike_bundle),
    .i_trace        (i_trace),
    .o_pop          (pop),
    .o_psum         (psum)
  );

  // Frame FSM and row/pass/beat counters; an early i_done drops the partial pass
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pass_d  = pass_q;
    beat_d  = beat_q;
    err_d   = err_q;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          accept  = 1'b1;
          state_d = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (i_done && (beat_q < LAST_BEAT)) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (i_valid) begin
          accept  = 1'b1;
          state_d = (beat_q == LAST_BEAT) ? ST_FLUSH : ST_RECV;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_FLUSH: begin
        err_d   = err_q | i_valid;
        state_d = frame_done_q ? ST_DONE : ST_FLUSH;
      end
      ST_DONE: begin
        err_d   = err_q | i_valid;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      row_d  = {IDX_W{1'b0}};
      pass_d = {IDX_W{1'b0}};
      beat_d = {BEAT_W{1'b0}};
    end else if (accept) begin
      if (beat_q == LAST_BEAT) begin
        row_d  = {IDX_W{1'b0}};
        pass_d = {IDX_W{1'b0}};
        beat_d = {BEAT_W{1'b0}};
      end else if (row_q == LAST_ROW) begin
        row_d  = {IDX_W{1'b0}};
        pass_d = pass_q + IDX_W'(1);
        beat_d = beat_q + BEAT_W'(1);
      end else begin
        row_d  = row_q + IDX_W'(1);
        beat_d = beat_q + BEAT_W'(1);
      end
    end else begin
      row_d  = row_q;
    end
  end

  assign last_row = accept && (row_q == LAST_ROW);

  // A completed row 23 already in stage 1 survives an abort; anything else is partial
  always_comb begin
    row_sum = {ROWSUM_W{1'b0}};
    for (int g = 0; g < N_GRP; g++) begin
      row_sum = row_sum + {{(ROWSUM_W-PSUM_W){1'b0}}, psum[g]};
    end
    contrib_en = p1_vld_q && (!abort || p1_last_q);
    clear_acc  = p2_last_q || (abort && !p1_last_q);
    if (contrib_en) begin
      spk_add = {{(SPK_ACC_W-POP_W){1'b0}}, pop};
      ltp_add = {{(LTP_ACC_W-ROWSUM_W){1'b0}}, row_sum};
    end else begin
      spk_add = {SPK_ACC_W{1'b0}};
      ltp_add = {LTP_ACC_W{1'b0}};
    end
    if (clear_acc) begin
      spk_acc_d = spk_add;
      ltp_acc_d = ltp_add;
    end else begin
      spk_acc_d = spk_acc_q + spk_add;
      ltp_acc_d = ltp_acc_q + ltp_add;
    end
  end

  // Control state, counters and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      row_q   <= {IDX_W{1'b0}};
      pass_q  <= {IDX_W{1'b0}};
      beat_q  <= {BEAT_W{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pass_q  <= pass_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Pass-end side pipeline and accumulators
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_vld_q  <= 1'b0;
      p1_last_q <= 1'b0;
      p1_post_q <= 1'b0;
      p1_idx_q  <= {IDX_W{1'b0}};
      p2_last_q <= 1'b0;
      p2_post_q <= 1'b0;
      p2_idx_q  <= {IDX_W{1'b0}};
      spk_acc_q <= {SPK_ACC_W{1'b0}};
      ltp_acc_q <= {LTP_ACC_W{1'b0}};
    end else begin
      p1_vld_q  <= accept;
      p1_last_q <= last_row;
      p1_post_q <= last_row && i_post_spike[pass_q];
      p1_idx_q  <= pass_q;
      p2_last_q <= p1_vld_q && p1_last_q;
      p2_post_q <= p1_post_q;
      p2_idx_q  <= p1_idx_q;
      spk_acc_q <= spk_acc_d;
      ltp_acc_q <= ltp_acc_d;
    end
  end

  // Result registers, zero whenever no result is being presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nrn_valid_q  <= 1'b0;
      nrn_idx_q    <= {IDX_W{1'b0}};
      nrn_cnt_q    <= {SPK_ACC_W{1'b0}};
      ltp_sum_q    <= {LTP_ACC_W{1'b0}};
      frame_done_q <= 1'b0;
    end else if (p2_last_q) begin
      nrn_valid_q  <= 1'b1;
      nrn_idx_q    <= p2_idx_q;
      nrn_cnt_q    <= spk_acc_q;
      ltp_sum_q    <= p2_post_q ? ltp_acc_q : {LTP_ACC_W{1'b0}};
      frame_done_q <= (p2_idx_q == LAST_NRN);
    end else begin
      nrn_valid_q  <= 1'b0;
      nrn_idx_q    <= {IDX_W{1'b0}};
      nrn_cnt_q    <= {SPK_ACC_W{1'b0}};
      ltp_sum_q    <= {LTP_ACC_W{1'b0}};
      frame_done_q <= 1'b0;
    end
  end

  assign o_nrn_valid     = nrn_valid_q;
  assign o_nrn_idx       = nrn_idx_q;
  assign o_nrn_spike_cnt = nrn_cnt_q;
  assign o_ltp_sum       = ltp_sum_q;
  assign o_frame_done    = frame_done_q;
  assign o_err           = err_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_pre_bundle_rx.sv
// Self-checking bench for pre_bundle_rx: table-driven frames, a randomized frame
// against a per-pass arithmetic model, and hand-written timing/abort/reset cases.
module tb_pre_bundle_rx;

  localparam int ROWS  = 24;
  localparam int NRNS  = 18;
  localparam int BEATS = ROWS * NRNS;

  localparam int K_ALL  = 0;
  localparam int K_DIAG = 1;
  localparam int K_RAND = 2;

  logic         clk;
  logic         reset_n;
  logic [23:0]  i_spike_bundle;
  logic [383:0] i_trace;
  logic         i_valid;
  logic         i_done;
  logic [17:0]  i_post_spike;
  logic         o_nrn_valid;
  logic [4:0]   o_nrn_idx;
  logic [9:0]   o_nrn_spike_cnt;
  logic [25:0]  o_ltp_sum;
  logic         o_frame_done;
  logic         o_err;
  logic         o_busy;

  pre_bundle_rx #(.ROWS(ROWS), .NRNS(NRNS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_spike_bundle  (i_spike_bundle),
    .i_trace         (i_trace),
    .i_valid         (i_valid),
    .i_done          (i_done),
    .i_post_spike    (i_post_spike),
    .o_nrn_valid     (o_nrn_valid),
    .o_nrn_idx       (o_nrn_idx),
    .o_nrn_spike_cnt (o_nrn_spike_cnt),
    .o_ltp_sum       (o_ltp_sum),
    .o_frame_done    (o_frame_done),
    .o_err           (o_err),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    int cnt;
    int ltp;
    int fd;
  } res_t;
  res_t rec_q[$];

  typedef struct {
    int          kind;
    logic [15:0] tr;
    logic [17:0] post;
    int          gapmax;
    bit          done_last;
    bit          use_model;
    int          exp_spk;
    int          exp_ltp;
  } vec_t;
  vec_t vecs[6];

  logic [23:0]  spk_a  [BEATS];
  logic [383:0] trc_a  [BEATS];
  logic [17:0]  post_a [BEATS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Collect results; outputs must be zero between pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_nrn_valid) begin
        rec_q.push_back('{int'(o_nrn_idx), int'(o_nrn_spike_cnt), int'(o_ltp_sum), int'(o_frame_done)});
      end else begin
        check("zero_when_idle", 64'({o_nrn_idx, o_nrn_spike_cnt, o_ltp_sum, o_frame_done}), 64'(0));
      end
    end
  end

  task automatic fill_frame(input int kind, input logic [15:0] tr, input logic [17:0] post);
    for (int b = 0; b < BEATS; b++) begin
      int r = b % ROWS;
      case (kind)
        K_ALL: begin
          spk_a[b] = 24'hFFFFFF;
          for (int k = 0; k < ROWS; k++) trc_a[b][16*k +: 16] = tr;
          post_a[b] = post;
        end
        K_DIAG: begin
          spk_a[b] = 24'd1 << r;
          trc_a[b] = '0;
          trc_a[b][16*r +: 16] = 16'(r + 1);
          post_a[b] = post;
        end
        default: begin
          spk_a[b] = 24'($urandom);
          for (int k = 0; k < 12; k++) trc_a[b][32*k +: 32] = $urandom;
          post_a[b] = 18'($urandom);
        end
      endcase
    end
  endtask

  // Beats with random idle gaps; i_post_spike is inverted while idle
  task automatic drive_beats(input int first, input int count, input int gapmax, input bit done_last);
    for (int b = first; b < first + count; b++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom % 32'(gapmax + 1)) : 0;
      for (int c = 0; c < g; c++) begin
        i_post_spike = ~post_a[b];
        @(posedge clk);
        #1;
      end
      i_valid        = 1'b1;
      i_spike_bundle = spk_a[b];
      i_trace        = trc_a[b];
      i_post_spike   = post_a[b];
      i_done         = done_last && (b == BEATS - 1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_done  = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (o_busy && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("busy_drops_after_frame", 64'(o_busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Per-pass expectation: constants from the table or sums over the stored frame
  task automatic check_results(input string tag, input int n_exp, input bit use_model,
                               input int exp_spk, input int exp_ltp);
    check({tag, ".n_results"}, 64'(rec_q.size()), 64'(n_exp));
    for (int n = 0; n < n_exp && n < rec_q.size(); n++) begin
      int m_spk = 0;
      int m_ltp = 0;
      int e_spk, e_ltp;
      bit post;
      for (int r = 0; r < ROWS; r++) begin
        m_spk += $countones(spk_a[n*ROWS + r]);
        for (int k = 0; k < ROWS; k++) m_ltp += int'(trc_a[n*ROWS + r][16*k +: 16]);
      end
      post  = post_a[n*ROWS + ROWS - 1][n];
      e_spk = use_model ? m_spk : exp_spk;
      e_ltp = post ? (use_model ? m_ltp : exp_ltp) : 0;
      check($sformatf("%s.idx[%0d]", tag, n), 64'(rec_q[n].idx), 64'(n));
      check($sformatf("%s.spike_cnt[%0d]", tag, n), 64'(rec_q[n].cnt), 64'(e_spk));
      check($sformatf("%s.ltp_sum[%0d]", tag, n), 64'(rec_q[n].ltp), 64'(e_ltp));
      check($sformatf("%s.frame_done[%0d]", tag, n), 64'(rec_q[n].fd), 64'(n == NRNS - 1));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rec_q.delete();
  endtask

  initial begin
    reset_n        = 1'b0;
    i_valid        = 1'b0;
    i_done         = 1'b0;
    i_spike_bundle = '0;
    i_trace        = '0;
    i_post_spike   = '0;

    vecs[0] = '{K_ALL,  16'h0001, 18'h3FFFF, 0, 1'b1, 1'b0, 576, 576};
    vecs[1] = '{K_ALL,  16'hFFFF, 18'h00001, 0, 1'b0, 1'b0, 576, 37748160};
    vecs[2] = '{K_DIAG, 16'h0000, 18'h3FFFF, 0, 1'b0, 1'b0, 24, 300};
    vecs[3] = '{K_DIAG, 16'h0000, 18'h3FFFF, 5, 1'b0, 1'b0, 24, 300};
    vecs[4] = '{K_RAND, 16'h0000, 18'h00000, 3, 1'b0, 1'b1, 0, 0};
    vecs[5] = '{K_RAND, 16'h0000, 18'h00000, 0, 1'b1, 1'b1, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst.nrn_valid", 64'(o_nrn_valid), 64'(0));
    check("rst.outputs", 64'({o_nrn_idx, o_nrn_spike_cnt, o_ltp_sum, o_frame_done}), 64'(0));
    check("rst.err", 64'(o_err), 64'(0));
    check("rst.busy", 64'(o_busy), 64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      rec_q.delete();
      fill_frame(vecs[v].kind, vecs[v].tr, vecs[v].post);
      drive_beats(0, BEATS, vecs[v].gapmax, vecs[v].done_last);
      wait_idle(40);
      check({tag, ".err"}, 64'(o_err), 64'(0));
      check_results(tag, NRNS, vecs[v].use_model, vecs[v].exp_spk, vecs[v].exp_ltp);
    end

    // Last-beat latency, stray beat in FLUSH, DONE one cycle after frame_done
    rec_q.delete();
    fill_frame(K_ALL, 16'h0001, 18'h3FFFF);
    drive_beats(0, BEATS - 1, 0, 1'b0);
    i_valid        = 1'b1;
    i_spike_bundle = spk_a[BEATS-1];
    i_trace        = trc_a[BEATS-1];
    i_post_spike   = post_a[BEATS-1];
    @(posedge clk);
    #1;
    check("lat.valid_plus1", 64'(o_nrn_valid), 64'(0));
    check("lat.err_before_stray", 64'(o_err), 64'(0));
    i_spike_bundle = 24'hFFFFFF;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("lat.valid_plus2", 64'(o_nrn_valid), 64'(0));
    check("flush_valid.err", 64'(o_err), 64'(1));
    @(posedge clk);
    #1;
    check("lat.valid_plus3", 64'(o_nrn_valid), 64'(1));
    check("lat.frame_done_plus3", 64'(o_frame_done), 64'(1));
    check("lat.idx_plus3", 64'(o_nrn_idx), 64'(17));
    @(posedge clk);
    #1;
    check("lat.valid_plus4", 64'(o_nrn_valid), 64'(0));
    check("lat.busy_in_done", 64'(o_busy), 64'(1));
    @(posedge clk);
    #1;
    check("lat.busy_after_done", 64'(o_busy), 64'(0));
    check_results("lat", NRNS, 1'b0, 576, 576);

    // Early i_done after 100 beats
    do_reset();
    fill_frame(K_ALL, 16'h0001, 18'h3FFFF);
    drive_beats(0, 100, 0, 1'b0);
    i_done = 1'b1;
    @(posedge clk);
    #1;
    i_done = 1'b0;
    check("abort.busy", 64'(o_busy), 64'(0));
    check("abort.err", 64'(o_err), 64'(1));
    repeat (8) @(posedge clk);
    #1;
    check("abort.err_sticky", 64'(o_err), 64'(1));
    check_results("abort", 4, 1'b0, 576, 576);

    // Reset in the middle of a frame, then a clean frame
    do_reset();
    check("post_abort_reset.err", 64'(o_err), 64'(0));
    fill_frame(K_ALL, 16'h0001, 18'h3FFFF);
    drive_beats(0, 200, 2, 1'b0);
    check("midrst.busy_before", 64'(o_busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("midrst.async_busy", 64'(o_busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rec_q.delete();
    drive_beats(0, BEATS, 0, 1'b0);
    wait_idle(40);
    check("midrst.err", 64'(o_err), 64'(0));
    check_results("midrst", NRNS, 1'b0, 576, 576);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
